// File: rtl/keying_modulator.sv
// Keying modulator for the DDS datapath.
// Picks one of 2^SYM_BITS tone sample streams (FSK) or a derived OOK/BPSK form of tone 0,
// driven by a double-buffered symbol code at a programmable symbol rate. Symbol changes are
// deferred until the outgoing and incoming samples are within ZC_WIN of each other, bounded
// by WAIT_MAX seek cycles and by the next symbol-period terminal count.
//
// Ports:
//   clk_100M      system clock
//   rst_n         asynchronous active-low reset
//   tone_bus      tone k at [k*DATA_W +: DATA_W], unsigned offset-binary
//   code          symbol code, symbol i at [i*SYM_BITS +: SYM_BITS]
//   sym_period    clocks per symbol (0 behaves as 1)
//   mode          0/3 = FSK, 1 = OOK, 2 = BPSK
//   enable        run (1) / stop (0)
//   mod_out       registered modulated sample
//   sym_idx       index of the symbol currently on mod_out
//   sym_strobe    one-cycle pulse on a symbol commit
//   forced_switch one-cycle pulse, commit was not at a near-crossing
//   frame_done    one-cycle pulse when the index wraps from 0 to CODE_LEN-1
module keying_modulator #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SYM_BITS = 1,
    parameter int unsigned CODE_LEN = 16,
    parameter int unsigned DIV_W    = 32,
    parameter int unsigned ZC_WIN   = 50,
    parameter int unsigned WAIT_MAX = 1023
) (
    input  logic                            clk_100M,
    input  logic                            rst_n,
    input  logic [DATA_W*(2**SYM_BITS)-1:0] tone_bus,
    input  logic [CODE_LEN*SYM_BITS-1:0]    code,
    input  logic [DIV_W-1:0]                sym_period,
    input  logic [1:0]                      mode,
    input  logic                            enable,
    output logic [DATA_W-1:0]               mod_out,
    output logic [$clog2(CODE_LEN)-1:0]     sym_idx,
    output logic                            sym_strobe,
    output logic                            forced_switch,
    output logic                            frame_done
);

    localparam int unsigned NT     = 2 ** SYM_BITS;
    localparam int unsigned IDX_W  = $clog2(CODE_LEN);
    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned CODE_W = CODE_LEN * SYM_BITS;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
    localparam logic [DIFF_W-1:0] ZC_LIM   = DIFF_W'(ZC_WIN);
    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StSeek} state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     mod_out_q, mod_out_d;
    logic [IDX_W-1:0]      sym_idx_q, sym_idx_d;
    logic                  strobe_q, strobe_d;
    logic                  forced_q, forced_d;
    logic                  frame_q, frame_d;
    logic [DIV_W-1:0]      count_q, count_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [1:0]            mode_q, mode_d;

    logic [DIV_W-1:0]      period_m1;
    logic                  at_term;
    logic [IDX_W-1:0]      next_idx;
    logic                  wrap;
    logic [SYM_BITS-1:0]   cur_sym, cand_sym;
    logic [DATA_W-1:0]     cur_smp, cand_smp;
    logic [DIFF_W-1:0]     cur_ext, cand_ext, diff;
    logic                  zc_ok, commit;

    function automatic logic [DATA_W-1:0] map_sample(input logic [SYM_BITS-1:0]  s,
                                                     input logic [1:0]           m,
                                                     input logic [DATA_W*NT-1:0] tones);
        logic [DATA_W-1:0] tone0;
        tone0 = tones[DATA_W-1:0];
        unique case (m)
            2'd1:    map_sample = s[0] ? tone0 : MID;
            2'd2:    map_sample = s[0] ? ~tone0 : tone0;
            default: map_sample = tones[int'(s) * DATA_W +: DATA_W];
        endcase
    endfunction

    // Decode shared by the next-state and datapath processes.
    always_comb begin
        period_m1 = (sym_period == '0) ? '0 : sym_period - 1'b1;
        // >= keeps the counter bounded if sym_period shrinks while running
        at_term   = (count_q >= period_m1);
        next_idx  = (sym_idx_q == '0) ? LAST_IDX : sym_idx_q - 1'b1;
        wrap      = (next_idx == LAST_IDX);
        cur_sym   = code_q[int'(sym_idx_q) * SYM_BITS +: SYM_BITS];
        // On a wrap the incoming symbol comes from the code being loaded, not the old frame
        cand_sym  = wrap ? code[int'(next_idx) * SYM_BITS +: SYM_BITS]
                         : code_q[int'(next_idx) * SYM_BITS +: SYM_BITS];
        cur_smp   = map_sample(cur_sym, mode_q, tone_bus);
        cand_smp  = map_sample(cand_sym, mode, tone_bus);
        cur_ext   = {1'b0, cur_smp};
        cand_ext  = {1'b0, cand_smp};
        diff      = (cur_ext >= cand_ext) ? cur_ext - cand_ext : cand_ext - cur_ext;
        zc_ok     = (diff <= ZC_LIM);
        commit    = (state_q == StSeek) && enable && (zc_ok || (wait_q == WAIT_LIM) || at_term);
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mod_out_q <= '0;
            sym_idx_q <= LAST_IDX;
            strobe_q  <= 1'b0;
            forced_q  <= 1'b0;
            frame_q   <= 1'b0;
            count_q   <= '0;
            wait_q    <= '0;
            code_q    <= '0;
            mode_q    <= '0;
        end else begin
            state_q   <= state_d;
            mod_out_q <= mod_out_d;
            sym_idx_q <= sym_idx_d;
            strobe_q  <= strobe_d;
            forced_q  <= forced_d;
            frame_q   <= frame_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            code_q    <= code_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   if (at_term) state_d = StSeek;
                StSeek:  if (commit) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mod_out_d = mod_out_q;
        sym_idx_d = sym_idx_q;
        strobe_d  = 1'b0;
        forced_d  = 1'b0;
        frame_d   = 1'b0;
        count_d   = count_q;
        wait_d    = wait_q;
        code_d    = code_q;
        mode_d    = mode_q;
        if (!enable) begin
            mod_out_d = MID;
            sym_idx_d = LAST_IDX;
            count_d   = '0;
            wait_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    mod_out_d = MID;
                    sym_idx_d = LAST_IDX;
                    count_d   = '0;
                    wait_d    = '0;
                    code_d    = code;
                    mode_d    = mode;
                end
                StRun: begin
                    mod_out_d = cur_smp;
                    count_d   = at_term ? '0 : count_q + 1'b1;
                    wait_d    = '0;
                end
                StSeek: begin
                    count_d = at_term ? '0 : count_q + 1'b1;
                    if (commit) begin
                        mod_out_d = cand_smp;
                        sym_idx_d = next_idx;
                        mode_d    = mode;
                        strobe_d  = 1'b1;
                        forced_d  = !zc_ok;
                        frame_d   = wrap;
                        wait_d    = '0;
                        if (wrap) code_d = code;
                    end else begin
                        mod_out_d = cur_smp;
                        wait_d    = wait_q + 1'b1;
                    end
                end
                default: mod_out_d = MID;
            endcase
        end
    end

    assign mod_out       = mod_out_q;
    assign sym_idx       = sym_idx_q;
    assign sym_strobe    = strobe_q;
    assign forced_switch = forced_q;
    assign frame_done    = frame_q;

endmodule

// File: tb/tb_keying_modulator.sv
module tb_keying_modulator;

    localparam int MID = 32768;

    logic        clk_100M = 1'b0;
    logic        rst_n;
    logic [31:0] tone_bus;
    logic [15:0] code;
    logic [31:0] sym_period;
    logic [1:0]  mode;
    logic        enable;
    logic [15:0] mod_out;
    logic [3:0]  sym_idx;
    logic        sym_strobe, forced_switch, frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_100M = ~clk_100M;

    keying_modulator dut (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .tone_bus      (tone_bus),
        .code          (code),
        .sym_period    (sym_period),
        .mode          (mode),
        .enable        (enable),
        .mod_out       (mod_out),
        .sym_idx       (sym_idx),
        .sym_strobe    (sym_strobe),
        .forced_switch (forced_switch),
        .frame_done    (frame_done)
    );

    // Advance one clock and sit 1 ns after the edge, where outputs are sampled and inputs driven.
    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    // Leaves the bench at sample t=0: the first edge on which the DUT has seen enable=1.
    task automatic start_run();
        enable = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        step();
    endtask

    // Output sample for symbol bit s under mode m with constant tones t0/t1.
    function automatic int smp(input bit s, input int m, input int t0, input int t1);
        case (m)
            1:       return s ? t0 : MID;
            2:       return s ? 65535 - t0 : t0;
            default: return s ? t1 : t0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; code = '0; mode = 2'd0; sym_period = 32'd10; tone_bus = '0;
        repeat (3) step();
        n_cmp++;
        if (mod_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mod_out: got %h want 0000", mod_out);
        end
        n_cmp++;
        if (sym_idx !== 4'd15) begin
            n_fail++; $display("FAIL reset_sym_idx: got %0d want 15", sym_idx);
        end
        n_cmp++;
        if ({sym_strobe, forced_switch, frame_done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000",
                               {sym_strobe, forced_switch, frame_done});
        end
        rst_n = 1'b1;
        n_cmp++;
        if (mod_out !== 16'h0000) begin
            n_fail++; $display("FAIL release_no_edge: got %h want 0000", mod_out);
        end
        step();
        n_cmp++;
        if (mod_out !== 16'h8000) begin
            n_fail++; $display("FAIL idle_mid: got %h want 8000", mod_out);
        end
        step();
        n_cmp++;
        if ({mod_out, sym_idx} !== {16'h8000, 4'd15}) begin
            n_fail++; $display("FAIL idle_hold: got %h/%0d want 8000/15", mod_out, sym_idx);
        end
    endtask

    // Constant tones; code may change once mid-frame and mode once mid-symbol. The model derives
    // the commit times from the symbol-period grid and the near-crossing rule, then checks every
    // cycle of the run.
    task automatic test_frame_run(input string nm, input logic [15:0] c0, input logic [15:0] c1,
                                  input int t0, input int t1, input int p, input int m0,
                                  input int m1, input int kc, input int km);
        localparam int NEV = 18;
        int ev_t[NEV];
        int ev_idx[NEV];
        int ev_smp[NEV];
        bit ev_frc[NEV];
        bit ev_frm[NEV];
        int cur_idx, cur_mode, seek, tc_code, tm_mode, init_smp, n, mk, cur_s, cand_s, d, len;
        int t_end, run_fail, e_idx, e_smp;
        bit e_stb, e_frc, e_frm;
        logic [15:0] cur_code, cand_code, em;
        logic [3:0]  ei;
        logic [22:0] obs, expv;

        cur_idx = 15; cur_mode = m0; cur_code = c0; seek = p; tc_code = -1; tm_mode = -1;
        init_smp = smp(c0[15], m0, t0, t1);
        for (int k = 0; k < NEV; k++) begin
            if (k == kc) tc_code = seek - p / 2;
            if (k == km) tm_mode = seek - p / 2;
            n         = (cur_idx == 0) ? 15 : cur_idx - 1;
            mk        = (k >= km) ? m1 : m0;
            cand_code = (n == 15 && k >= kc) ? c1 : cur_code;
            cur_s     = smp(cur_code[cur_idx], cur_mode, t0, t1);
            cand_s    = smp(cand_code[n], mk, t0, t1);
            d         = (cur_s > cand_s) ? cur_s - cand_s : cand_s - cur_s;
            len       = (d <= 50) ? 1 : ((p < 1024) ? p : 1024);
            ev_t[k]   = seek + len;
            ev_idx[k] = n;
            ev_smp[k] = cand_s;
            ev_frc[k] = (d > 50);
            ev_frm[k] = (n == 15);
            cur_idx   = n;
            cur_mode  = mk;
            cur_code  = cand_code;
            // Seeks begin on the period grid, at the first wrap after the previous commit
            seek      = (ev_t[k] / p + 1) * p;
        end

        tone_bus   = {t1[15:0], t0[15:0]};
        code       = c0;
        mode       = m0[1:0];
        sym_period = 32'(p);
        start_run();
        t_end = ev_t[NEV-1] + 3;
        run_fail = 0;
        for (int t = 0; t <= t_end; t++) begin
            if (t == tc_code) code = c1;
            if (t == tm_mode) mode = m1[1:0];
            e_idx = 15; e_smp = init_smp; e_stb = 0; e_frc = 0; e_frm = 0;
            for (int k = 0; k < NEV; k++) begin
                if (ev_t[k] <= t) begin
                    e_idx = ev_idx[k];
                    e_smp = ev_smp[k];
                end
                if (ev_t[k] == t) begin
                    e_stb = 1; e_frc = ev_frc[k]; e_frm = ev_frm[k];
                end
            end
            if (t == 0) e_smp = MID;
            em   = e_smp[15:0];
            ei   = e_idx[3:0];
            expv = {em, ei, e_stb, e_frc, e_frm};
            obs  = {mod_out, sym_idx, sym_strobe, forced_switch, frame_done};
            n_cmp++;
            if (obs !== expv) begin
                n_fail++; run_fail++;
                $display("FAIL %s t=%0d: got out=%h idx=%0d stb/frc/frm=%b want out=%h idx=%0d stb/frc/frm=%b",
                         nm, t, mod_out, sym_idx, {sym_strobe, forced_switch, frame_done},
                         em, ei, {e_stb, e_frc, e_frm});
                if (run_fail >= 5) break;
            end
            step();
        end
        enable = 1'b0;
    endtask

    task automatic test_seek_delay();
        int v;
        tone_bus = {16'd2000, 16'd1000}; code = 16'h4000; mode = 2'd0; sym_period = 32'd100;
        start_run();
        repeat (100) step();
        for (int j = 0; j <= 97; j++) begin
            n_cmp++;
            if (sym_strobe !== (j == 96)) begin
                n_fail++; $display("FAIL seek_strobe j=%0d: got %b want %b", j, sym_strobe, j == 96);
            end
            if (j == 96) begin
                n_cmp++;
                if ({mod_out, sym_idx, forced_switch} !== {16'd1050, 4'd14, 1'b0}) begin
                    n_fail++; $display("FAIL seek_commit: got %0d/%0d/%b want 1050/14/0",
                                       mod_out, sym_idx, forced_switch);
                end
            end else if (j < 96) begin
                n_cmp++;
                if (mod_out !== 16'd1000) begin
                    n_fail++; $display("FAIL seek_hold j=%0d: got %0d want 1000", j, mod_out);
                end
            end
            if (j <= 95) begin
                v = 2000 - 10 * j;
                tone_bus = {v[15:0], 16'd1000};
            end
            step();
        end
        n_cmp++;
        if (mod_out !== 16'd1050) begin
            n_fail++; $display("FAIL seek_after: got %0d want 1050", mod_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_timeout();
        tone_bus = {16'd40000, 16'd0}; code = 16'h4000; mode = 2'd0; sym_period = 32'd5000;
        start_run();
        repeat (6023) step();
        n_cmp++;
        if ({sym_strobe, sym_idx, mod_out} !== {1'b0, 4'd15, 16'd0}) begin
            n_fail++; $display("FAIL timeout_early: got stb=%b idx=%0d out=%0d want 0/15/0",
                               sym_strobe, sym_idx, mod_out);
        end
        step();
        n_cmp++;
        if ({sym_strobe, forced_switch, sym_idx, mod_out} !== {1'b1, 1'b1, 4'd14, 16'd40000}) begin
            n_fail++; $display("FAIL timeout_commit: got stb=%b frc=%b idx=%0d out=%0d want 1/1/14/40000",
                               sym_strobe, forced_switch, sym_idx, mod_out);
        end
        enable = 1'b0;
        sym_period = 32'd200;
        start_run();
        repeat (399) step();
        n_cmp++;
        if (sym_strobe !== 1'b0) begin
            n_fail++; $display("FAIL term_early: got %b want 0", sym_strobe);
        end
        step();
        n_cmp++;
        if ({sym_strobe, forced_switch, sym_idx} !== {1'b1, 1'b1, 4'd14}) begin
            n_fail++; $display("FAIL term_commit: got stb=%b frc=%b idx=%0d want 1/1/14",
                               sym_strobe, forced_switch, sym_idx);
        end
        enable = 1'b0;
    endtask

    task automatic test_bpsk_ook();
        tone_bus = {16'h1234, 16'h1000}; code = 16'hC000; mode = 2'd2; sym_period = 32'd50;
        start_run();
        step();
        n_cmp++;
        if (mod_out !== 16'hEFFF) begin
            n_fail++; $display("FAIL bpsk_one: got %h want efff", mod_out);
        end
        repeat (9) step();
        mode = 2'd0;
        repeat (89) step();
        n_cmp++;
        if ({mod_out, sym_strobe} !== {16'hEFFF, 1'b0}) begin
            n_fail++; $display("FAIL mode_mid_symbol: got %h/%b want efff/0", mod_out, sym_strobe);
        end
        step();
        n_cmp++;
        if ({mod_out, sym_strobe, forced_switch} !== {16'h1234, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL mode_after_strobe: got %h/%b/%b want 1234/1/1",
                               mod_out, sym_strobe, forced_switch);
        end
        enable = 1'b0;
        code = 16'h4000; mode = 2'd1;
        start_run();
        step();
        n_cmp++;
        if (mod_out !== 16'h8000) begin
            n_fail++; $display("FAIL ook_zero: got %h want 8000", mod_out);
        end
        repeat (99) step();
        n_cmp++;
        if ({mod_out, sym_strobe} !== {16'h1000, 1'b1}) begin
            n_fail++; $display("FAIL ook_one: got %h/%b want 1000/1", mod_out, sym_strobe);
        end
        enable = 1'b0;
    endtask

    task automatic test_stop_restart();
        tone_bus = {16'd1030, 16'd1000}; code = 16'h5A5A; mode = 2'd0; sym_period = 32'd30;
        start_run();
        repeat (45) step();
        enable = 1'b0;
        step();
        n_cmp++;
        if ({mod_out, sym_idx, sym_strobe, forced_switch, frame_done} !== {16'h8000, 4'd15, 3'b000}) begin
            n_fail++; $display("FAIL stop_state: got %h/%0d/%b want 8000/15/000", mod_out, sym_idx,
                               {sym_strobe, forced_switch, frame_done});
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_cmp++;
            if ({mod_out, sym_strobe, forced_switch, frame_done} !== {16'h8000, 3'b000}) begin
                n_fail++; $display("FAIL stopped i=%0d: got %h/%b want 8000/000", i, mod_out,
                                   {sym_strobe, forced_switch, frame_done});
            end
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if ({mod_out, sym_idx} !== {16'h8000, 4'd15}) begin
            n_fail++; $display("FAIL restart_t0: got %h/%0d want 8000/15", mod_out, sym_idx);
        end
        step();
        n_cmp++;
        if (mod_out !== 16'd1000) begin
            n_fail++; $display("FAIL restart_first: got %0d want 1000", mod_out);
        end
        repeat (29) step();
        n_cmp++;
        if (sym_strobe !== 1'b0) begin
            n_fail++; $display("FAIL restart_early: got %b want 0", sym_strobe);
        end
        step();
        n_cmp++;
        if ({sym_strobe, forced_switch, sym_idx, mod_out} !== {1'b1, 1'b0, 4'd14, 16'd1030}) begin
            n_fail++; $display("FAIL restart_commit: got %b/%b/%0d/%0d want 1/0/14/1030",
                               sym_strobe, forced_switch, sym_idx, mod_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_async_reset();
        tone_bus = {16'd5000, 16'd4000}; code = 16'hFFFF; mode = 2'd0; sym_period = 32'd20;
        start_run();
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mod_out, sym_idx} !== {16'h0000, 4'd15}) begin
            n_fail++; $display("FAIL async_reset: got %h/%0d want 0000/15", mod_out, sym_idx);
        end
        enable = 1'b0;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (mod_out !== 16'h8000) begin
            n_fail++; $display("FAIL async_release: got %h want 8000", mod_out);
        end
    endtask

    initial begin
        int t0, t1;
        test_reset();
        test_frame_run("fsk_a5a5", 16'hA5A5, 16'(32'($urandom)), 1000, 1020, 100, 0, 0, 6, 99);
        for (int r = 0; r < 3; r++) begin
            t0 = int'($urandom_range(60000, 1000));
            t1 = ($urandom_range(1, 0) == 1) ? t0 + int'($urandom_range(60, 0))
                                             : int'($urandom_range(65535, 0));
            test_frame_run("rand_run", 16'(32'($urandom)), 16'(32'($urandom)), t0, t1,
                           int'($urandom_range(60, 20)), int'($urandom_range(3, 0)),
                           int'($urandom_range(3, 0)), int'($urandom_range(14, 3)),
                           int'($urandom_range(12, 2)));
        end
        test_seek_delay();
        test_timeout();
        test_bpsk_ook();
        test_stop_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
